masked_popcount_acc: RTL and testbench
======================================

Name: masked_popcount_acc

Overview:
- Downstream consumer of the N-bit scalar-gated vector stage (y = a & g per bit).
- Accepts one masked vector per valid/ready beat and accumulates set-bit counts over a frame terminated by in_last.
- Presents the frame's total set bits and beat count on a registered valid/ready result port.

Parameters:
N, 4, width of the incoming masked vector
SUM_W, 8, width of the set-bit accumulator and out_sum
WC_W, 4, width of the beat counter and out_words

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_data/in_last valid this cycle
in_ready  output  1  block can accept a beat
in_data  input  N  masked vector from gating stage
in_last  input  1  final beat of frame
out_valid  output  1  frame result valid
out_ready  input  1  downstream accepts result
out_sum  output  SUM_W  total set bits in frame, saturating
out_words  output  WC_W  beats in frame, saturating
out_ovf  output  1  either counter saturated during frame

Behaviour:
- One clock, clk; rst_n asynchronous active-low: on assertion all state clears immediately, without waiting for a clock edge.
- Reset values: state=IDLE, acc_sum=0, acc_words=0, acc_ovf=0, out_valid=0, out_sum=0, out_words=0, out_ovf=0. in_ready=1 after reset.
- Accept condition: in_valid && in_ready at a rising clk.
- States:
  - IDLE: accumulators zero. in_ready=1. Accept with in_last=0 -> ACC. Accept with in_last=1 -> HOLD (single-beat frame).
  - ACC: in_ready=1. Each accept updates the accumulators. Accept with in_last=1 -> HOLD.
  - HOLD: in_ready=0, out_valid=1. on out_valid && out_ready -> IDLE; accumulators and ovf clear on the same edge.
- Accumulate arithmetic per accepted beat:
  - p = popcount(in_data), range 0..N.
  - acc_sum = min(acc_sum + p, 2^SUM_W-1); computed at SUM_W+1 bits before clamping.
  - acc_words = min(acc_words + 1, 2^WC_W-1).
  - acc_ovf is set if either clamp engages and stays set until the frame is consumed.
- Result capture: on the in_last accept edge, out_sum/out_words/out_ovf load the updated values (including the last beat). out_valid rises on that same edge, so the result is visible the cycle after the last beat: latency 1.
- out_sum/out_words/out_ovf hold stable while out_valid=1 and out_ready=0. They retain their values after consumption; only out_valid drops.
- No bypass: after the out handshake, in_ready returns to 1 the following cycle. No beat is accepted in the handshake cycle.
- in_valid=0 cycles inside a frame (bubbles) leave accumulators unchanged.
- in_data is not interpreted beyond popcount. The g=0 upstream case (all-zero vectors) counts as beats with p=0.
- in_last while in_valid=0 is ignored.
- Reset asserted mid-frame or in HOLD discards the partial or pending result. out_valid drops immediately.

Test Plan:
- Single frame: beats 4'b1011, 4'b0000, 4'b1111 (last), out_ready=1 -> one cycle after the last beat, out_valid=1, out_sum=7, out_words=3, out_ovf=0; in_ready=0 that cycle, 1 the cycle after the handshake.
- Single-beat frame: 4'b0110 with in_last=1 from IDLE -> out_sum=2, out_words=1 next cycle. Repeat with g=0 upstream (4'b0000, last) -> out_sum=0, out_words=1.
- Backpressure: complete a frame with out_ready=0 for 5 cycles -> out_valid and outputs stable, in_ready=0, an in_valid=1 beat during HOLD is not accepted. Raise out_ready -> next frame starts clean (out_sum excludes the old frame).
- Saturation: 17 beats of 4'b1111 (last on the 17th) -> out_words=15, out_sum=68, out_ovf=1. Use SUM_W=6 and 16 beats of 4'b1111 -> out_sum=63, out_ovf=1.
- Bubbles: beats 4'b0001, gap of 3 idle cycles, 4'b0011 (last) -> out_sum=3, out_words=2.
- Reset: assert rst_n=0 asynchronously after 2 beats of a frame, then in HOLD -> all outputs 0 immediately. The next frame 4'b1000 (last) yields out_sum=1, out_words=1.

Source files
------------

// File: rtl/masked_popcount_acc.sv
// Frame accumulator for masked vectors: counts set bits and beats per frame
// and presents the saturating totals on a registered valid/ready result port.
module masked_popcount_acc #(
  parameter int N     = 4,
  parameter int SUM_W = 8,
  parameter int WC_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] out_sum,
  output logic [WC_W-1:0]  out_words,
  output logic             out_ovf
);

  localparam int PW = $clog2(N + 1);

  // Handshake: a beat moves when in_valid && in_ready at a rising clk; a
  // result moves when out_valid && out_ready. Payloads are stable while
  // their valid is high and ready is low.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic [SUM_W-1:0] acc_sum;
  logic [WC_W-1:0]  acc_words;
  logic             acc_ovf;

  logic             accept;
  logic             consume;
  logic [PW-1:0]    pop;
  logic [SUM_W:0]   sum_wide;
  logic             sum_clamp;
  logic             words_clamp;
  logic [SUM_W-1:0] sum_next;
  logic [WC_W-1:0]  words_next;
  logic             ovf_next;

  assign accept  = in_valid && in_ready;
  assign consume = out_valid && out_ready;

  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++) begin
      pop = pop + PW'(in_data[i]);
    end
  end

  // One guard bit above the accumulator catches the carry before clamping.
  assign sum_wide    = {1'b0, acc_sum} + (SUM_W + 1)'(pop);
  assign sum_clamp   = sum_wide[SUM_W];
  assign sum_next    = sum_clamp ? {SUM_W{1'b1}} : sum_wide[SUM_W-1:0];
  assign words_clamp = (acc_words == {WC_W{1'b1}});
  assign words_next  = words_clamp ? acc_words : acc_words + 1'b1;
  assign ovf_next    = acc_ovf || sum_clamp || words_clamp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept) next_state = in_last ? HOLD : ACC;
      ACC:  if (accept && in_last) next_state = HOLD;
      HOLD: if (consume) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state != HOLD);
    out_valid = (state == HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_sum   <= '0;
      acc_words <= '0;
      acc_ovf   <= 1'b0;
      out_sum   <= '0;
      out_words <= '0;
      out_ovf   <= 1'b0;
    end else if (consume) begin
      acc_sum   <= '0;
      acc_words <= '0;
      acc_ovf   <= 1'b0;
    end else if (accept) begin
      acc_sum   <= sum_next;
      acc_words <= words_next;
      acc_ovf   <= ovf_next;
      if (in_last) begin
        out_sum   <= sum_next;
        out_words <= words_next;
        out_ovf   <= ovf_next;
      end
    end
  end

endmodule

// File: tb/tb_masked_popcount_acc.sv
// Bench for masked_popcount_acc: two instances (SUM_W=8 and SUM_W=6) share
// one stimulus stream and are checked against a per-frame arithmetic model.
module tb_masked_popcount_acc;

  localparam int N    = 4;
  localparam int WC_W = 4;
  localparam int EW   = 1 + WC_W + 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = '0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b0;

  logic       in_ready_a, out_valid_a, out_ovf_a;
  logic [7:0] out_sum_a;
  logic [3:0] out_words_a;
  logic       in_ready_b, out_valid_b, out_ovf_b;
  logic [5:0] out_sum_b;
  logic [3:0] out_words_b;

  int n_checks = 0;
  int n_errors = 0;

  int frame_pops[$];
  logic [EW-1:0] exp_a_q[$];
  logic [EW-1:0] exp_b_q[$];

  always #5 clk = ~clk;

  masked_popcount_acc #(.N(N), .SUM_W(8), .WC_W(WC_W)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_sum(out_sum_a), .out_words(out_words_a),
    .out_ovf(out_ovf_a)
  );

  masked_popcount_acc #(.N(N), .SUM_W(6), .WC_W(WC_W)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_sum(out_sum_b), .out_words(out_words_b),
    .out_ovf(out_ovf_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected frame result straight from the rules: clamp raw totals.
  function automatic logic [EW-1:0] frame_result(input int sum_w);
    int total = 0;
    int beats = frame_pops.size();
    int smax  = (1 << sum_w) - 1;
    int wmax  = (1 << WC_W) - 1;
    logic ovf;
    logic [7:0] s;
    logic [3:0] w;
    foreach (frame_pops[i]) total += frame_pops[i];
    ovf = (total > smax) || (beats > wmax);
    s = 8'((total > smax) ? smax : total);
    w = 4'((beats > wmax) ? wmax : beats);
    return {ovf, w, s};
  endfunction

  task automatic send_beat(input logic [3:0] d, input logic l, input int bubbles);
    int guard = 0;
    repeat (bubbles) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready_a && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready_a) begin
      chk("in_ready_timeout", in_ready_a, 1);
    end else begin
      chk("in_ready_match", in_ready_b, in_ready_a);
      @(posedge clk);
      frame_pops.push_back($countones(d));
      if (l) begin
        exp_a_q.push_back(frame_result(8));
        exp_b_q.push_back(frame_result(6));
        frame_pops.delete();
      end
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_outputs(input string tag, input logic [EW-1:0] ea, input logic [EW-1:0] eb);
    chk({tag, "_sum_a"},   out_sum_a,   ea[7:0]);
    chk({tag, "_words_a"}, out_words_a, ea[11:8]);
    chk({tag, "_ovf_a"},   out_ovf_a,   ea[12]);
    chk({tag, "_sum_b"},   out_sum_b,   eb[5:0]);
    chk({tag, "_words_b"}, out_words_b, eb[11:8]);
    chk({tag, "_ovf_b"},   out_ovf_b,   eb[12]);
  endtask

  // Called right after the last beat's accepting edge.
  task automatic take_result(input int stall);
    logic [EW-1:0] ea, eb;
    @(negedge clk);
    chk("valid_latency_a", out_valid_a, 1);
    chk("valid_latency_b", out_valid_b, 1);
    chk("in_ready_hold", in_ready_a, 0);
    if (exp_a_q.size() == 0 || exp_b_q.size() == 0) begin
      chk("exp_queue_empty", 0, 1);
      return;
    end
    ea = exp_a_q.pop_front();
    eb = exp_b_q.pop_front();
    check_outputs("result", ea, eb);
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      in_data  = 4'hF;
      in_last  = 1'b1;
      @(negedge clk);
      chk("stall_valid", out_valid_a, 1);
      chk("stall_in_ready", in_ready_a, 0);
      check_outputs("stall", ea, eb);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    chk("valid_drop_a", out_valid_a, 0);
    chk("valid_drop_b", out_valid_b, 0);
    chk("in_ready_back", in_ready_a, 1);
    check_outputs("retain", ea, eb);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, out_valid_a | out_valid_b, 0);
    chk({tag, "_in_ready"}, in_ready_a & in_ready_b, 1);
    chk({tag, "_sum"}, {out_sum_a, 2'b00, out_sum_b}, 0);
    chk({tag, "_words"}, {out_words_a, out_words_b}, 0);
    chk({tag, "_ovf"}, out_ovf_a | out_ovf_b, 0);
  endtask

  initial begin
    int len;
    #12;
    check_reset_outputs("reset_init");
    @(negedge clk);
    rst_n = 1'b1;

    // Single frame, out_ready effectively immediate
    send_beat(4'b1011, 1'b0, 0);
    send_beat(4'b0000, 1'b0, 0);
    send_beat(4'b1111, 1'b1, 0);
    take_result(0);
    chk("plan_single_sum", out_sum_a, 7);
    chk("plan_single_words", out_words_a, 3);

    // Single-beat frames, including an all-zero vector
    send_beat(4'b0110, 1'b1, 0);
    take_result(0);
    chk("plan_one_beat_sum", out_sum_a, 2);
    send_beat(4'b0000, 1'b1, 0);
    take_result(0);
    chk("plan_zero_words", out_words_a, 1);

    // Backpressure with an intruding beat during HOLD
    send_beat(4'b0101, 1'b0, 0);
    send_beat(4'b0001, 1'b1, 0);
    take_result(5);
    send_beat(4'b0010, 1'b1, 0);
    take_result(0);
    chk("plan_clean_after_bp", out_sum_a, 1);

    // Saturation: 16 beats then 17 beats of all ones
    for (int i = 0; i < 16; i++) send_beat(4'b1111, i == 15, 0);
    take_result(0);
    chk("plan_sat16_sum_b", out_sum_b, 63);
    for (int i = 0; i < 17; i++) send_beat(4'b1111, i == 16, 0);
    take_result(0);
    chk("plan_sat17_sum_a", out_sum_a, 68);
    chk("plan_sat17_words_a", out_words_a, 15);

    // Bubbles inside a frame
    send_beat(4'b0001, 1'b0, 0);
    send_beat(4'b0011, 1'b1, 3);
    take_result(0);
    chk("plan_bubble_sum", out_sum_a, 3);

    // Asynchronous reset mid-frame
    send_beat(4'b1111, 1'b0, 0);
    send_beat(4'b1111, 1'b0, 0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("reset_mid");
    frame_pops.delete();
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset while holding a result
    send_beat(4'b0111, 1'b1, 0);
    @(negedge clk);
    chk("hold_before_reset", out_valid_a, 1);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("reset_hold");
    exp_a_q.delete();
    exp_b_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send_beat(4'b1000, 1'b1, 0);
    take_result(0);
    chk("plan_after_reset_sum", out_sum_a, 1);
    chk("plan_after_reset_words", out_words_a, 1);

    // Random frames
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(1, 20);
      for (int b = 0; b < len; b++) begin
        send_beat(4'($urandom_range(0, 15)), b == len - 1, $urandom_range(0, 2));
      end
      take_result($urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
